// File: rtl/dbus_pkg.sv
// Shared types and constants for the two-master data-bus arbiter.
package dbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // One-hot bus owner: bit 0 = master 0 (core), bit 1 = master 1 (DMA/debug).
    typedef logic [1:0] gnt_t;

    localparam gnt_t GNT_NONE = 2'b00;
    localparam gnt_t GNT_M0   = 2'b01;
    localparam gnt_t GNT_M1   = 2'b10;

    localparam int TMO_CYC_DEF = 255;

    // Read data returned to a master whose slave never answered.
    localparam logic [31:0] ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/dbus_if.sv
// Data-bus bundle. The "master" modport is the side that issues transfers
// (the arbiter on the shared bus); the "slave" modport is the side that
// serves them (the arbiter facing each requesting master).
interface dbus_if;
    logic        das;
    logic        drd;
    logic        dwr;
    logic [31:0] daddr;
    logic [31:0] datao;
    logic [2:0]  dlen;
    logic [31:0] datai;
    logic        hlt;
    logic        rdy;

    modport master (
        output das, drd, dwr, daddr, datao, dlen,
        input  datai, rdy
    );

    modport slave (
        input  das, drd, dwr, daddr, datao, dlen,
        output datai, hlt
    );
endinterface

// File: rtl/dbus_rr_picker.sv
// Two-way request picker: fixed priority to master 0, or round-robin on a
// tie when RR_EN is set. Holds the last-grant memory.
module dbus_rr_picker
    import dbus_pkg::*;
#(
    parameter int RR_EN = 1
) (
    input  logic clk,
    input  logic res,
    input  logic req0,
    input  logic req1,
    input  logic take,
    output gnt_t pick
);

    // 0 after reset means master 1 was granted last, so master 0 wins first.
    logic last_m0;

    // Choose a winner; on a tie, round-robin favours whoever was not granted last.
    always_comb begin
        pick = GNT_NONE;
        if (req0 && req1) begin
            pick = ((RR_EN != 0) && last_m0) ? GNT_M1 : GNT_M0;
        end else if (req0) begin
            pick = GNT_M0;
        end else if (req1) begin
            pick = GNT_M1;
        end
    end

    // Remember the owner each time a grant is actually taken.
    always_ff @(posedge clk) begin
        if (res) begin
            last_m0 <= 1'b0;
        end else if (take && (pick != GNT_NONE)) begin
            last_m0 <= (pick == GNT_M0);
        end
    end

endmodule

// File: rtl/dbus_arbiter.sv
// Arbitrates two data-bus masters onto one shared slave bus, one transfer
// at a time, with a slave-ready timeout that returns error data on reads.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no transfer; pick a winner and latch its request
// ST_ACCESS | shared-bus strobes active, waiting for slave ready/timeout
// ST_DONE   | completion cycle; owner sees HLT low, ERR pulses on timeout
module dbus_arbiter
    import dbus_pkg::*;
#(
    parameter int TMO_CYC = TMO_CYC_DEF,
    parameter int RR_EN   = 1
) (
    input  logic   clk,
    input  logic   res,
    dbus_if.slave  m0,
    dbus_if.slave  m1,
    dbus_if.master s,
    output logic   err,
    output gnt_t   gnt
);

    // Counter value in the ACCESS cycle where it reaches TMO_CYC.
    localparam logic [7:0] TMO_LAST = 8'(TMO_CYC - 1);

    state_t      state;
    state_t      state_nxt;
    gnt_t        pick;
    logic        m0_req;
    logic        m1_req;
    logic        tmo_hit;
    logic        xfer_end;
    logic        lat_rd_only;
    logic [7:0]  cnt;
    logic        lat_drd;
    logic        lat_dwr;
    logic [31:0] lat_daddr;
    logic [31:0] lat_datao;
    logic [2:0]  lat_dlen;
    logic [31:0] m0_datai;
    logic [31:0] m1_datai;

    // A strobe without read or write is not a request and never stalls.
    assign m0_req = m0.das & (m0.drd | m0.dwr);
    assign m1_req = m1.das & (m1.drd | m1.dwr);

    assign tmo_hit     = (cnt == TMO_LAST);
    assign xfer_end    = (state == ST_ACCESS) && (s.rdy || tmo_hit);
    // Read and write together is executed as a write.
    assign lat_rd_only = lat_drd & ~lat_dwr;

    assign s.daddr  = lat_daddr;
    assign s.datao  = lat_datao;
    assign s.dlen   = lat_dlen;
    assign m0.datai = m0_datai;
    assign m1.datai = m1_datai;

    dbus_rr_picker #(
        .RR_EN (RR_EN)
    ) u_picker (
        .clk  (clk),
        .res  (res),
        .req0 (m0_req),
        .req1 (m1_req),
        .take (state == ST_IDLE),
        .pick (pick)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, shared-bus strobes and master stalls.
    always_comb begin
        state_nxt = state;
        s.das     = 1'b0;
        s.drd     = 1'b0;
        s.dwr     = 1'b0;
        m0.hlt    = m0_req;
        m1.hlt    = m1_req;
        case (state)
            ST_IDLE: begin
                if (pick != GNT_NONE) begin
                    state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                s.das = 1'b1;
                s.drd = lat_rd_only;
                s.dwr = lat_dwr;
                if (s.rdy || tmo_hit) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                state_nxt = ST_IDLE;
                // A reset landing on the completion cycle suppresses it.
                if (!res) begin
                    m0.hlt = m0_req & ~gnt[0];
                    m1.hlt = m1_req & ~gnt[1];
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Grant, request latch, timeout counter, error pulse and read-data return.
    always_ff @(posedge clk) begin
        if (res) begin
            gnt       <= GNT_NONE;
            cnt       <= 8'd0;
            err       <= 1'b0;
            lat_drd   <= 1'b0;
            lat_dwr   <= 1'b0;
            lat_daddr <= 32'd0;
            lat_datao <= 32'd0;
            lat_dlen  <= 3'd0;
            m0_datai  <= 32'd0;
            m1_datai  <= 32'd0;
        end else begin
            err <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pick != GNT_NONE) begin
                        gnt <= pick;
                        cnt <= 8'd0;
                        if (pick == GNT_M0) begin
                            lat_drd   <= m0.drd;
                            lat_dwr   <= m0.dwr;
                            lat_daddr <= m0.daddr;
                            lat_datao <= m0.datao;
                            lat_dlen  <= m0.dlen;
                        end else begin
                            lat_drd   <= m1.drd;
                            lat_dwr   <= m1.dwr;
                            lat_daddr <= m1.daddr;
                            lat_datao <= m1.datao;
                            lat_dlen  <= m1.dlen;
                        end
                    end
                end
                ST_ACCESS: begin
                    cnt <= cnt + 8'd1;
                    if (xfer_end) begin
                        // Ready in the timeout cycle still counts as a normal finish.
                        err <= ~s.rdy;
                        if (lat_rd_only && gnt[0]) begin
                            m0_datai <= s.rdy ? s.datai : ERR_DATA;
                        end
                        if (lat_rd_only && gnt[1]) begin
                            m1_datai <= s.rdy ? s.datai : ERR_DATA;
                        end
                    end
                end
                ST_DONE: begin
                    gnt <= GNT_NONE;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Bench for dbus_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the arbitration rules.
module tb_dbus_arbiter;
    import dbus_pkg::*;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    // Master-side stimulus, shared by both arbiter instances.
    logic        das  [2];
    logic        drd  [2];
    logic        dwr  [2];
    logic [31:0] addr [2];
    logic [31:0] wd   [2];
    logic [2:0]  len  [2];
    logic        rdy;
    logic [31:0] sdat;

    dbus_if m0_a (), m1_a (), s_a ();
    dbus_if m0_b (), m1_b (), s_b ();
    logic       err_a, err_b;
    logic [1:0] gnt_a, gnt_b;

    assign m0_a.das = das[0];   assign m0_a.drd = drd[0];   assign m0_a.dwr = dwr[0];
    assign m0_a.daddr = addr[0]; assign m0_a.datao = wd[0]; assign m0_a.dlen = len[0];
    assign m1_a.das = das[1];   assign m1_a.drd = drd[1];   assign m1_a.dwr = dwr[1];
    assign m1_a.daddr = addr[1]; assign m1_a.datao = wd[1]; assign m1_a.dlen = len[1];
    assign m0_b.das = das[0];   assign m0_b.drd = drd[0];   assign m0_b.dwr = dwr[0];
    assign m0_b.daddr = addr[0]; assign m0_b.datao = wd[0]; assign m0_b.dlen = len[0];
    assign m1_b.das = das[1];   assign m1_b.drd = drd[1];   assign m1_b.dwr = dwr[1];
    assign m1_b.daddr = addr[1]; assign m1_b.datao = wd[1]; assign m1_b.dlen = len[1];
    assign s_a.rdy = rdy;  assign s_a.datai = sdat;
    assign s_b.rdy = rdy;  assign s_b.datai = sdat;
    assign m0_a.rdy = 1'b0; assign m1_a.rdy = 1'b0; assign m0_b.rdy = 1'b0; assign m1_b.rdy = 1'b0;
    assign s_a.hlt = 1'b0;  assign s_b.hlt = 1'b0;

    dbus_arbiter #(.TMO_CYC(4), .RR_EN(1)) dut_a (
        .clk(clk), .res(res), .m0(m0_a), .m1(m1_a), .s(s_a), .err(err_a), .gnt(gnt_a)
    );
    dbus_arbiter #(.TMO_CYC(4), .RR_EN(0)) dut_b (
        .clk(clk), .res(res), .m0(m0_b), .m1(m1_b), .s(s_b), .err(err_b), .gnt(gnt_b)
    );

    logic [1:0]  hlt_a;
    logic [31:0] dai_a [2];
    assign hlt_a    = {m1_a.hlt, m0_a.hlt};
    assign dai_a[0] = m0_a.datai;
    assign dai_a[1] = m1_a.datai;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic clr_in();
        for (int i = 0; i < 2; i++) begin
            das[i] = 1'b0; drd[i] = 1'b0; dwr[i] = 1'b0;
            addr[i] = 32'd0; wd[i] = 32'd0; len[i] = 3'd0;
        end
        rdy = 1'b0;
        sdat = 32'd0;
    endtask

    task automatic test_reset();
        res = 1'b1;
        clr_in();
        das[0] = 1'b1; drd[0] = 1'b1; addr[0] = 32'h55;
        nxt(); nxt(); mid();
        n_chk++; if (gnt_a !== 2'b00) $display("FAIL rst_gnt_a: got %b want 00", gnt_a); else n_pass++;
        n_chk++; if (gnt_b !== 2'b00) $display("FAIL rst_gnt_b: got %b want 00", gnt_b); else n_pass++;
        n_chk++; if (s_a.das !== 1'b0) $display("FAIL rst_sdas: got %b want 0", s_a.das); else n_pass++;
        n_chk++; if ({s_a.drd, s_a.dwr} !== 2'b00) $display("FAIL rst_strobes: got %b want 00", {s_a.drd, s_a.dwr}); else n_pass++;
        n_chk++; if (err_a !== 1'b0) $display("FAIL rst_err: got %b want 0", err_a); else n_pass++;
        n_chk++; if (dai_a[0] !== 32'd0) $display("FAIL rst_dai0: got %h want 0", dai_a[0]); else n_pass++;
        n_chk++; if (dai_a[1] !== 32'd0) $display("FAIL rst_dai1: got %h want 0", dai_a[1]); else n_pass++;
        n_chk++; if ({s_a.daddr, s_a.datao, s_a.dlen} !== 67'd0) $display("FAIL rst_latch: got %h want 0", {s_a.daddr, s_a.datao, s_a.dlen}); else n_pass++;
        n_chk++; if (hlt_a !== 2'b01) $display("FAIL rst_hlt: got %b want 01", hlt_a); else n_pass++;
        nxt();
        res = 1'b0;
        clr_in();
        mid();
        n_chk++; if (gnt_a !== 2'b00) $display("FAIL rst_idle_gnt: got %b want 00", gnt_a); else n_pass++;
        nxt();
    endtask

    task automatic test_read();
        das[0] = 1'b1; drd[0] = 1'b1; addr[0] = 32'h100; len[0] = 3'd2;
        mid();
        n_chk++; if (hlt_a[0] !== 1'b1) $display("FAIL rd_hlt_c0: got %b want 1", hlt_a[0]); else n_pass++;
        nxt();
        rdy = 1'b1; sdat = 32'h1234_5678;
        mid();
        n_chk++; if (gnt_a !== 2'b01) $display("FAIL rd_gnt: got %b want 01", gnt_a); else n_pass++;
        n_chk++; if ({s_a.das, s_a.drd, s_a.dwr} !== 3'b110) $display("FAIL rd_strobes: got %b want 110", {s_a.das, s_a.drd, s_a.dwr}); else n_pass++;
        n_chk++; if (s_a.daddr !== 32'h100) $display("FAIL rd_addr: got %h want 100", s_a.daddr); else n_pass++;
        n_chk++; if (s_a.dlen !== 3'd2) $display("FAIL rd_len: got %0d want 2", s_a.dlen); else n_pass++;
        n_chk++; if (hlt_a[0] !== 1'b1) $display("FAIL rd_hlt_c1: got %b want 1", hlt_a[0]); else n_pass++;
        nxt();
        rdy = 1'b0;
        mid();
        n_chk++; if (hlt_a[0] !== 1'b0) $display("FAIL rd_hlt_c2: got %b want 0", hlt_a[0]); else n_pass++;
        n_chk++; if (dai_a[0] !== 32'h1234_5678) $display("FAIL rd_data: got %h want 12345678", dai_a[0]); else n_pass++;
        n_chk++; if (err_a !== 1'b0) $display("FAIL rd_err: got %b want 0", err_a); else n_pass++;
        nxt();
        clr_in();
        mid();
        n_chk++; if ({s_a.das, gnt_a} !== 3'b000) $display("FAIL rd_idle: got %b want 000", {s_a.das, gnt_a}); else n_pass++;
        n_chk++; if (dai_a[0] !== 32'h1234_5678) $display("FAIL rd_hold: got %h want 12345678", dai_a[0]); else n_pass++;
        nxt();
    endtask

    task automatic test_write_timeout();
        das[1] = 1'b1; dwr[1] = 1'b1; addr[1] = 32'h200; wd[1] = 32'hDEAD_BEEF;
        mid();
        n_chk++; if (hlt_a[1] !== 1'b1) $display("FAIL wt_hlt_c0: got %b want 1", hlt_a[1]); else n_pass++;
        for (int k = 1; k <= 4; k++) begin
            nxt(); mid();
            n_chk++; if ({s_a.das, s_a.dwr, hlt_a[1], err_a} !== 4'b1110) $display("FAIL wt_access%0d: got %b want 1110", k, {s_a.das, s_a.dwr, hlt_a[1], err_a}); else n_pass++;
            if (k == 1) begin
                n_chk++; if (gnt_a !== 2'b10) $display("FAIL wt_gnt: got %b want 10", gnt_a); else n_pass++;
                n_chk++; if ({s_a.daddr, s_a.datao} !== {32'h200, 32'hDEAD_BEEF}) $display("FAIL wt_addr_data: got %h want 00000200deadbeef", {s_a.daddr, s_a.datao}); else n_pass++;
            end
        end
        nxt(); mid();
        n_chk++; if ({s_a.das, hlt_a[1], err_a} !== 3'b001) $display("FAIL wt_done: got %b want 001", {s_a.das, hlt_a[1], err_a}); else n_pass++;
        n_chk++; if (dai_a[1] !== 32'd0) $display("FAIL wt_dai1: got %h want 0", dai_a[1]); else n_pass++;
        nxt();
        clr_in();
        mid();
        n_chk++; if (err_a !== 1'b0) $display("FAIL wt_err_pulse: got %b want 0", err_a); else n_pass++;
        nxt();
    endtask

    task automatic test_read_timeout();
        das[0] = 1'b1; drd[0] = 1'b1; addr[0] = 32'h180;
        for (int k = 1; k <= 4; k++) begin
            nxt(); mid();
            n_chk++; if ({s_a.das, hlt_a[0], err_a} !== 3'b110) $display("FAIL rt_access%0d: got %b want 110", k, {s_a.das, hlt_a[0], err_a}); else n_pass++;
        end
        nxt(); mid();
        n_chk++; if ({hlt_a[0], err_a} !== 2'b01) $display("FAIL rt_done: got %b want 01", {hlt_a[0], err_a}); else n_pass++;
        n_chk++; if (dai_a[0] !== 32'hFFFF_FFFF) $display("FAIL rt_data: got %h want ffffffff", dai_a[0]); else n_pass++;
        nxt();
        clr_in();
        mid();
        n_chk++; if (err_a !== 1'b0) $display("FAIL rt_err_pulse: got %b want 0", err_a); else n_pass++;
        nxt();
    endtask

    task automatic test_rdy_at_limit();
        das[0] = 1'b1; drd[0] = 1'b1; addr[0] = 32'h300;
        for (int k = 1; k <= 4; k++) begin
            nxt();
            rdy = (k == 4); sdat = 32'hA5A5_0F0F;
            mid();
            n_chk++; if (s_a.das !== 1'b1) $display("FAIL lim_access%0d: got %b want 1", k, s_a.das); else n_pass++;
        end
        nxt();
        rdy = 1'b0;
        mid();
        n_chk++; if ({hlt_a[0], err_a} !== 2'b00) $display("FAIL lim_done: got %b want 00", {hlt_a[0], err_a}); else n_pass++;
        n_chk++; if (dai_a[0] !== 32'hA5A5_0F0F) $display("FAIL lim_data: got %h want a5a50f0f", dai_a[0]); else n_pass++;
        nxt();
        clr_in();
        nxt();
    endtask

    task automatic test_owner_drop();
        das[1] = 1'b1; drd[1] = 1'b1; addr[1] = 32'h400;
        nxt(); mid();
        n_chk++; if (gnt_a !== 2'b10) $display("FAIL drop_gnt: got %b want 10", gnt_a); else n_pass++;
        nxt();
        das[1] = 1'b0; drd[1] = 1'b0; rdy = 1'b1; sdat = 32'h0BAD_F00D;
        mid();
        n_chk++; if ({s_a.das, hlt_a[1]} !== 2'b10) $display("FAIL drop_access: got %b want 10", {s_a.das, hlt_a[1]}); else n_pass++;
        nxt();
        rdy = 1'b0;
        mid();
        n_chk++; if (dai_a[1] !== 32'h0BAD_F00D) $display("FAIL drop_data: got %h want 0badf00d", dai_a[1]); else n_pass++;
        n_chk++; if ({gnt_a, hlt_a[1]} !== 3'b100) $display("FAIL drop_done: got %b want 100", {gnt_a, hlt_a[1]}); else n_pass++;
        nxt(); mid();
        n_chk++; if (gnt_a !== 2'b00) $display("FAIL drop_idle: got %b want 00", gnt_a); else n_pass++;
        nxt();
    endtask

    task automatic test_reset_mid();
        das[0] = 1'b1; drd[0] = 1'b1; addr[0] = 32'h500;
        nxt();
        nxt();
        res = 1'b1;
        mid();
        n_chk++; if (s_a.das !== 1'b1) $display("FAIL rmid_access2: got %b want 1", s_a.das); else n_pass++;
        nxt(); mid();
        n_chk++; if ({s_a.das, gnt_a} !== 3'b000) $display("FAIL rmid_idle: got %b want 000", {s_a.das, gnt_a}); else n_pass++;
        n_chk++; if (dai_a[0] !== 32'd0) $display("FAIL rmid_dai0: got %h want 0", dai_a[0]); else n_pass++;
        n_chk++; if (hlt_a[0] !== 1'b1) $display("FAIL rmid_hlt: got %b want 1", hlt_a[0]); else n_pass++;
        nxt();
        res = 1'b0;
        clr_in();
        mid();
        n_chk++; if ({gnt_a, err_a} !== 3'b000) $display("FAIL rmid_after: got %b want 000", {gnt_a, err_a}); else n_pass++;
        nxt();
    endtask

    task automatic test_ignored();
        das[0] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            mid();
            n_chk++; if ({hlt_a[0], s_a.das, gnt_a} !== 4'b0000) $display("FAIL ign_c%0d: got %b want 0000", k, {hlt_a[0], s_a.das, gnt_a}); else n_pass++;
            nxt();
        end
        clr_in();
        nxt();
    endtask

    task automatic test_back_to_back_arb();
        logic [1:0] exp_a;
        das[0] = 1'b1; dwr[0] = 1'b1; addr[0] = 32'h10;
        das[1] = 1'b1; dwr[1] = 1'b1; addr[1] = 32'h20;
        rdy = 1'b1;
        for (int t = 0; t < 4; t++) begin
            exp_a = (t % 2 == 0) ? 2'b01 : 2'b10;
            nxt(); mid();
            n_chk++; if (gnt_a !== exp_a) $display("FAIL arb_rr%0d: got %b want %b", t, gnt_a, exp_a); else n_pass++;
            n_chk++; if (gnt_b !== 2'b01) $display("FAIL arb_fp%0d: got %b want 01", t, gnt_b); else n_pass++;
            n_chk++; if (s_a.daddr !== ((t % 2 == 0) ? 32'h10 : 32'h20)) $display("FAIL arb_addr%0d: got %h", t, s_a.daddr); else n_pass++;
            nxt(); mid();
            n_chk++; if (hlt_a !== ~exp_a) $display("FAIL arb_hlt%0d: got %b want %b", t, hlt_a, ~exp_a); else n_pass++;
            nxt(); mid();
            n_chk++; if ({gnt_a, hlt_a} !== 4'b0011) $display("FAIL arb_idle%0d: got %b want 0011", t, {gnt_a, hlt_a}); else n_pass++;
        end
        clr_in();
        nxt();
    endtask

    task automatic test_random();
        logic        pend [2];
        logic [31:0] exp_dai [2];
        logic        last_m0;
        logic        tmo, rd_only;
        logic [1:0]  exp_gnt;
        int          win, oth, d, nacc, op;
        logic [31:0] sd;
        res = 1'b1;
        clr_in();
        nxt();
        res = 1'b0;
        pend[0] = 1'b0; pend[1] = 1'b0;
        exp_dai[0] = 32'd0; exp_dai[1] = 32'd0;
        last_m0 = 1'b0;
        for (int t = 0; t < 40; t++) begin
            for (int x = 0; x < 2; x++) begin
                if (!pend[x]) begin
                    if ($urandom_range(0, 1) == 1) begin
                        op = $urandom_range(0, 2);
                        pend[x] = 1'b1;
                        das[x] = 1'b1;
                        drd[x] = (op != 1);
                        dwr[x] = (op != 0);
                        addr[x] = $urandom; wd[x] = $urandom; len[x] = 3'($urandom_range(0, 7));
                    end else begin
                        das[x] = ($urandom_range(0, 3) == 0);
                        drd[x] = 1'b0; dwr[x] = 1'b0;
                    end
                end
            end
            if (!pend[0] && !pend[1]) begin
                win = $urandom_range(0, 1);
                pend[win] = 1'b1; das[win] = 1'b1; drd[win] = 1'b1; dwr[win] = 1'b0;
                addr[win] = $urandom; wd[win] = $urandom; len[win] = 3'($urandom_range(0, 7));
            end
            if (pend[0] && pend[1]) win = last_m0 ? 1 : 0;
            else win = pend[0] ? 0 : 1;
            oth = 1 - win;
            last_m0 = (win == 0);
            exp_gnt = 2'(1 << win);
            d = $urandom_range(0, 5);
            sd = $urandom;
            tmo = (d >= 4);
            nacc = tmo ? 4 : d + 1;
            rd_only = drd[win] & ~dwr[win];
            if (rd_only) exp_dai[win] = tmo ? 32'hFFFF_FFFF : sd;
            rdy = 1'b0;
            mid();
            n_chk++; if ({gnt_a, hlt_a} !== {2'b00, pend[1], pend[0]}) $display("FAIL rnd%0d_idle: got %b want %b", t, {gnt_a, hlt_a}, {2'b00, pend[1], pend[0]}); else n_pass++;
            for (int k = 1; k <= nacc; k++) begin
                nxt();
                rdy = (k == d + 1); sdat = sd;
                mid();
                n_chk++; if ({s_a.das, hlt_a[win]} !== 2'b11) $display("FAIL rnd%0d_access%0d: got %b want 11", t, k, {s_a.das, hlt_a[win]}); else n_pass++;
                if (k == 1) begin
                    n_chk++; if (gnt_a !== exp_gnt) $display("FAIL rnd%0d_gnt: got %b want %b", t, gnt_a, exp_gnt); else n_pass++;
                    n_chk++; if ({s_a.daddr, s_a.datao, s_a.dlen} !== {addr[win], wd[win], len[win]})
                        $display("FAIL rnd%0d_fields: got %h want %h", t, {s_a.daddr, s_a.datao, s_a.dlen}, {addr[win], wd[win], len[win]}); else n_pass++;
                    n_chk++; if ({s_a.drd, s_a.dwr} !== {rd_only, dwr[win]}) $display("FAIL rnd%0d_op: got %b want %b", t, {s_a.drd, s_a.dwr}, {rd_only, dwr[win]}); else n_pass++;
                end
            end
            nxt();
            rdy = 1'b0;
            mid();
            n_chk++; if ({hlt_a[win], hlt_a[oth], err_a} !== {1'b0, pend[oth], tmo}) $display("FAIL rnd%0d_done: got %b want %b", t, {hlt_a[win], hlt_a[oth], err_a}, {1'b0, pend[oth], tmo}); else n_pass++;
            n_chk++; if ({dai_a[0], dai_a[1]} !== {exp_dai[0], exp_dai[1]}) $display("FAIL rnd%0d_data: got %h want %h", t, {dai_a[0], dai_a[1]}, {exp_dai[0], exp_dai[1]}); else n_pass++;
            nxt();
            pend[win] = 1'b0; das[win] = 1'b0; drd[win] = 1'b0; dwr[win] = 1'b0;
        end
        clr_in();
        nxt();
    endtask

    initial begin
        res = 1'b1;
        clr_in();
        test_reset();
        test_read();
        test_write_timeout();
        test_read_timeout();
        test_rdy_at_limit();
        test_owner_drop();
        test_reset_mid();
        test_ignored();
        test_back_to_back_arb();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
